dino_motion_core: RTL and testbench
===================================

DINO_MOTION_CORE -- requirements
Module: dino_motion_core

Interface
REQ-001 SHALL have parameter SPRITE_DIV, default 4194304, pixel ticks per sprite-frame toggle.
REQ-002 SHALL have parameter MOVE_DIV, default 250000, pixel ticks per asteroid move step.
REQ-003 SHALL have parameter XSTEP, default 1, x increment per move step.
REQ-004 SHALL have parameter YSTEP, default 2, y increment per move step.
REQ-005 SHALL have parameters XWRAP, default 640, and YWRAP, default 480, as exclusive position limits.
REQ-006 SHALL have port clk, input, 1 bit, 100 MHz system clock and the block's only clock.
REQ-007 SHALL have port reset, input, 1 bit, asynchronous active-high reset.
REQ-008 SHALL have port halt, input, 1 bit, freezing asteroid motion while high (collision).
REQ-009 SHALL have port asteroid_on, input, 1 bit, enabling asteroid motion.
REQ-010 SHALL have port divided_clk, output, 1 bit, 25 MHz square wave (clk/4, 50% duty).
REQ-011 SHALL have port pix_tick, output, 1 bit, one-clk pulse per divided_clk period.
REQ-012 SHALL have port sprite, output, 1 bit, running-dino frame select (0/1).
REQ-013 SHALL have port xmovaddr, output, 10 bits, asteroid x offset in pixels.
REQ-014 SHALL have port ymovaddr, output, 10 bits, asteroid y offset in pixels.

Function
REQ-015 Clock divider: 2-bit counter div_cnt, incremented every clk and wrapping 3->0; divided_clk SHALL equal div_cnt[1].
REQ-016 pix_tick SHALL be high exactly in the clk cycle where div_cnt==3; all other logic SHALL run on clk, qualified by pix_tick (no derived clocks).
REQ-017 Sprite: counter spr_cnt SHALL count pix_ticks 0..SPRITE_DIV-1; on the tick where spr_cnt==SPRITE_DIV-1 it SHALL wrap to 0 and sprite SHALL invert on the same edge.
REQ-018 sprite SHALL toggle regardless of halt and asteroid_on.
REQ-019 Move timer: counter mv_cnt SHALL count pix_ticks 0..MOVE_DIV-1, wrapping to 0; a move step SHALL occur on the wrapping tick.
REQ-020 mv_cnt SHALL hold its value while halt=1 and SHALL run while halt=0, independent of asteroid_on.
REQ-021 On a move step with asteroid_on=1 and halt=0: xmovaddr SHALL become xmovaddr+XSTEP, or xmovaddr+XSTEP-XWRAP if the sum >= XWRAP.
REQ-022 On the same step, ymovaddr SHALL become ymovaddr+YSTEP, or ymovaddr+YSTEP-YWRAP if the sum >= YWRAP.
REQ-023 Position sums SHALL be computed at 11 bits to avoid 10-bit overflow before the wrap compare.
REQ-024 With asteroid_on=0 or halt=1, xmovaddr and ymovaddr SHALL hold their values.
REQ-025 halt and asteroid_on SHALL be sampled on the clk edge where pix_tick=1; there is no latency beyond that edge.
REQ-026 Outputs SHALL be registered, with no combinational path from any input to any output.

Reset
REQ-027 reset=1 SHALL asynchronously clear div_cnt, spr_cnt, mv_cnt, sprite, xmovaddr and ymovaddr to 0, forcing divided_clk=0 and pix_tick=0.
REQ-028 While reset is held, all state SHALL stay 0.
REQ-029 After reset deasserts, the first pix_tick SHALL be on the 4th clk rising edge.
REQ-030 reset SHALL take priority over halt; reset during halt SHALL return positions to 0.

Verification
REQ-031 Bench: release reset, run 16 clk -> divided_clk pattern 0,0,1,1 repeating, with pix_tick high on every 4th cycle (cycles 3,7,11,15).
REQ-032 Bench: SPRITE_DIV=4, run 32 pix_ticks -> sprite toggles every 4 ticks, giving 8 toggles and ending at 0.
REQ-033 Bench: MOVE_DIV=2, XSTEP=1, YSTEP=2, asteroid_on=1, 10 ticks -> xmovaddr=5, ymovaddr=10.
REQ-034 Bench: preload via steps to ymovaddr=478, then one step -> ymovaddr=0; likewise xmovaddr 639 -> 0.
REQ-035 Bench: halt=1 for 20 ticks mid-run -> positions and mv_cnt frozen while sprite keeps toggling; halt=0 resumes from the frozen values.
REQ-036 Bench: assert reset asynchronously between clk edges while positions are nonzero -> all outputs 0 immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/dino_motion_core.sv
// Divides clk by 4 into a pixel tick and drives the dino sprite toggle plus the wrapping asteroid offsets.
// All outputs are registered state; motion updates land on the clk edge where pix_tick is high.
module dino_motion_core #(
  parameter int SPRITE_DIV = 4194304,
  parameter int MOVE_DIV   = 250000,
  parameter int XSTEP      = 1,
  parameter int YSTEP      = 2,
  parameter int XWRAP      = 640,
  parameter int YWRAP      = 480
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       halt,
  input  logic       asteroid_on,
  output logic       divided_clk,
  output logic       pix_tick,
  output logic       sprite,
  output logic [9:0] xmovaddr,
  output logic [9:0] ymovaddr
);

  localparam int SW = (SPRITE_DIV > 1) ? $clog2(SPRITE_DIV) : 1;
  localparam int MW = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
  localparam logic [SW-1:0] SPR_LAST = SW'(SPRITE_DIV - 1);
  localparam logic [MW-1:0] MV_LAST  = MW'(MOVE_DIV - 1);

  logic [1:0]    div_cnt_q, div_cnt_d;
  logic [SW-1:0] spr_cnt_q, spr_cnt_d;
  logic [MW-1:0] mv_cnt_q, mv_cnt_d;
  logic          sprite_q, sprite_d;
  logic [9:0]    x_q, x_d, y_q, y_d;
  logic [10:0]   x_sum, y_sum;
  logic          tick;

  assign tick = (div_cnt_q == 2'd3);

  always_comb begin
    div_cnt_d = div_cnt_q + 2'd1;
    spr_cnt_d = spr_cnt_q;
    sprite_d  = sprite_q;
    mv_cnt_d  = mv_cnt_q;
    x_d       = x_q;
    y_d       = y_q;
    // 11-bit sums so a 10-bit carry cannot hide a wrap
    x_sum     = {1'b0, x_q} + 11'(XSTEP);
    y_sum     = {1'b0, y_q} + 11'(YSTEP);
    if (tick) begin
      if (spr_cnt_q == SPR_LAST) begin
        spr_cnt_d = '0;
        sprite_d  = ~sprite_q;
      end else begin
        spr_cnt_d = spr_cnt_q + SW'(1);
      end
      if (!halt) begin
        if (mv_cnt_q == MV_LAST) begin
          mv_cnt_d = '0;
          if (asteroid_on) begin
            x_d = (x_sum >= 11'(XWRAP)) ? 10'(x_sum - 11'(XWRAP)) : x_sum[9:0];
            y_d = (y_sum >= 11'(YWRAP)) ? 10'(y_sum - 11'(YWRAP)) : y_sum[9:0];
          end
        end else begin
          mv_cnt_d = mv_cnt_q + MW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt_q <= '0;
      spr_cnt_q <= '0;
      mv_cnt_q  <= '0;
      sprite_q  <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
      spr_cnt_q <= spr_cnt_d;
      mv_cnt_q  <= mv_cnt_d;
      sprite_q  <= sprite_d;
      x_q       <= x_d;
      y_q       <= y_d;
    end
  end

  assign divided_clk = div_cnt_q[1];
  assign pix_tick    = tick;
  assign sprite      = sprite_q;
  assign xmovaddr    = x_q;
  assign ymovaddr    = y_q;

endmodule

// File: tb/tb_dino_motion_core.sv
// Randomized bench for dino_motion_core against a count-based model of ticks, steps and wraps.
module tb_dino_motion_core;

  localparam int SPR = 4;
  localparam int MV  = 2;
  localparam int XS  = 1;
  localparam int YS  = 2;
  localparam int XW  = 640;
  localparam int YW  = 480;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       halt = 1'b0;
  logic       asteroid_on = 1'b0;
  logic       divided_clk;
  logic       pix_tick;
  logic       sprite;
  logic [9:0] xmovaddr;
  logic [9:0] ymovaddr;

  dino_motion_core #(
    .SPRITE_DIV(SPR), .MOVE_DIV(MV), .XSTEP(XS), .YSTEP(YS), .XWRAP(XW), .YWRAP(YW)
  ) dut (
    .clk(clk), .reset(reset), .halt(halt), .asteroid_on(asteroid_on),
    .divided_clk(divided_clk), .pix_tick(pix_tick), .sprite(sprite),
    .xmovaddr(xmovaddr), .ymovaddr(ymovaddr)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int e = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: clocks since reset, pixel ticks, unhalted ticks, and completed moves
  int m_cyc, m_n, m_m, m_k;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_cyc = 0; m_n = 0; m_m = 0; m_k = 0;
    end else begin
      if (m_cyc % 4 == 3) begin
        m_n++;
        if (!halt) begin
          m_m++;
          if ((m_m % MV == 0) && asteroid_on) m_k++;
        end
      end
      m_cyc++;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("divided_clk", int'(divided_clk), int'((m_cyc % 4) >= 2));
      chk("pix_tick", int'(pix_tick), int'((m_cyc % 4) == 3));
      chk("sprite", int'(sprite), (m_n / SPR) % 2);
      chk("xmovaddr", int'(xmovaddr), (m_k * XS) % XW);
      chk("ymovaddr", int'(ymovaddr), (m_k * YS) % YW);
    end
  end

  task automatic step_to(input int target);
    while (e < target) begin
      @(negedge clk);
      e++;
    end
  endtask

  task automatic chk_pos(input string name, input int xe, input int ye);
    chk({name, "_x"}, int'(xmovaddr), xe);
    chk({name, "_y"}, int'(ymovaddr), ye);
  endtask

  initial begin
    int toggles;
    logic prev;
    logic [3:0] pat;

    #1 reset = 1'b1;
    chk_en = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_div", int'(divided_clk), 0);
    chk("rst_tick", int'(pix_tick), 0);
    chk("rst_sprite", int'(sprite), 0);
    chk_pos("rst", 0, 0);

    @(negedge clk);
    asteroid_on = 1'b1;
    reset = 1'b0;
    pat = 4'b1100;
    toggles = 0;
    prev = 1'b0;
    for (int i = 0; i <= 128; i++) begin
      #1;
      if (i < 16) begin
        chk("div_pattern", int'(divided_clk), int'(pat[i % 4]));
        chk("tick_pattern", int'(pix_tick), int'((i % 4) == 3));
      end
      if (sprite != prev) toggles++;
      prev = sprite;
      if (i == 40) chk_pos("ten_ticks", 5, 10);
      if (i < 128) @(negedge clk);
    end
    e = 128;
    chk("sprite_toggles", toggles, 8);
    chk("sprite_end", int'(sprite), 0);

    step_to(1912); #1 chk_pos("y478", 239, 478);
    step_to(1920); #1 chk_pos("ywrap", 240, 0);
    step_to(5112); #1 chk_pos("x639", 639, 318);
    step_to(5120); #1 chk_pos("xwrap", 0, 320);

    step_to(5124);
    halt = 1'b1;
    step_to(5204);
    #1;
    chk_pos("halted", 0, 320);
    chk("halt_sprite", int'(sprite), 1);
    halt = 1'b0;
    step_to(5208); #1 chk_pos("resume", 1, 322);

    for (int t = 0; t < 600; t++) begin
      halt = ($urandom_range(0, 3) == 0);
      asteroid_on = ($urandom_range(0, 3) != 0);
      step_to(e + 4);
    end
    halt = 1'b1;
    step_to(e + 84);
    halt = 1'b0;
    asteroid_on = 1'b1;
    step_to(e + 12);

    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("async_div", int'(divided_clk), 0);
    chk("async_tick", int'(pix_tick), 0);
    chk("async_sprite", int'(sprite), 0);
    chk_pos("async", 0, 0);
    halt = 1'b1;
    repeat (2) @(negedge clk);
    halt = 1'b0;
    reset = 1'b0;
    e = 0;
    step_to(40);
    #1 chk_pos("post_reset", 5, 10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
